// File: rtl/noc_pkg.sv
// Shared NoC router constants: default flit width, VC count and per-VC depth,
// plus the VC index width helper used by every VC-aware block.
package noc_pkg;

  localparam int FLIT_W   = 8;
  localparam int VC_NUM   = 2;
  localparam int VC_DEPTH = 8;

  function automatic int vc_idx_w(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  localparam int VC_IDX_W = vc_idx_w(VC_NUM);

endpackage

// File: rtl/vc_fifo_ctrl.sv
// Pointer, flag and occupancy tracking for one virtual channel. The pointers
// carry one extra wrap bit so full and empty stay distinguishable.
module vc_fifo_ctrl
  import noc_pkg::*;
#(
  parameter int  DEPTH = VC_DEPTH,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic [IDX_W-1:0] rd_idx,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;

  // Advance each pointer on its accepted operation.
  always_comb begin
    wr_ptr_d = wr_en ? (wr_ptr_q + CNT_W'(1)) : wr_ptr_q;
    rd_ptr_d = rd_en ? (rd_ptr_q + CNT_W'(1)) : rd_ptr_q;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign wr_idx = wr_ptr_q[IDX_W-1:0];
  assign rd_idx = rd_ptr_q[IDX_W-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                  (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign count  = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/noc_vc_fifo.sv
// Multi-VC input flit buffer: NUM_VC FIFOs sharing one storage array, with a
// registered read port and one upstream credit per flit read out.
module noc_vc_fifo
  import noc_pkg::*;
#(
  parameter int  DATA_W = FLIT_W,
  parameter int  DEPTH  = VC_DEPTH,
  parameter int  NUM_VC = VC_NUM,
  localparam int VC_W   = vc_idx_w(NUM_VC),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       Data_in,
  input  logic                    write,
  input  logic [VC_W-1:0]         wr_vc,
  input  logic                    read,
  input  logic [VC_W-1:0]         rd_vc,
  output logic [DATA_W-1:0]       Data_out,
  output logic                    out_valid,
  output logic [NUM_VC-1:0]       empty,
  output logic [NUM_VC-1:0]       full,
  output logic [NUM_VC*CNT_W-1:0] count,
  output logic                    credit_out,
  output logic [VC_W-1:0]         credit_vc,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int IDX_W  = CNT_W - 1;
  localparam int WORDS  = NUM_VC * DEPTH;
  localparam int ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [NUM_VC-1:0] wr_en_s, rd_en_s, empty_s, full_s;
  logic [IDX_W-1:0]  wr_idx_s [NUM_VC];
  logic [IDX_W-1:0]  rd_idx_s [NUM_VC];
  logic [ADDR_W-1:0] wr_addr_s, rd_addr_s;
  logic              wr_acc_s, rd_acc_s;

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              credit_q, credit_d;
  logic [VC_W-1:0]   credit_vc_q, credit_vc_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  // Per-VC accept. Out-of-range VC indices match no VC and are rejected; a
  // write into a full VC is allowed only when a same-VC read frees a slot.
  always_comb begin
    rd_en_s   = '0;
    wr_en_s   = '0;
    rd_addr_s = '0;
    wr_addr_s = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (read && (rd_vc == VC_W'(v)) && !empty_s[v]) begin
        rd_en_s[v] = 1'b1;
        rd_addr_s  = ADDR_W'(v * DEPTH) + ADDR_W'(rd_idx_s[v]);
      end else begin
        rd_en_s[v] = 1'b0;
      end
      if (write && (wr_vc == VC_W'(v)) && (!full_s[v] || rd_en_s[v])) begin
        wr_en_s[v] = 1'b1;
        wr_addr_s  = ADDR_W'(v * DEPTH) + ADDR_W'(wr_idx_s[v]);
      end else begin
        wr_en_s[v] = 1'b0;
      end
    end
  end

  assign rd_acc_s = |rd_en_s;
  assign wr_acc_s = |wr_en_s;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    vc_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en_s[g]),
      .rd_en  (rd_en_s[g]),
      .wr_idx (wr_idx_s[g]),
      .rd_idx (rd_idx_s[g]),
      .empty  (empty_s[g]),
      .full   (full_s[g]),
      .count  (count[g*CNT_W +: CNT_W])
    );
  end

  // Storage is not reset; the pointers alone define which words are live.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wr_addr_s] <= Data_in;
    end
  end

  // Read port, credit and sticky error next state.
  always_comb begin
    if (rd_acc_s) begin
      data_d      = mem_q[rd_addr_s];
      credit_vc_d = rd_vc;
    end else begin
      data_d      = data_q;
      credit_vc_d = credit_vc_q;
    end
    valid_d     = rd_acc_s;
    credit_d    = rd_acc_s;
    overflow_d  = overflow_q | (write & ~wr_acc_s);
    underflow_d = underflow_q | (read & ~rd_acc_s);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      credit_q    <= 1'b0;
      credit_vc_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      credit_q    <= credit_d;
      credit_vc_q <= credit_vc_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign empty      = empty_s;
  assign full       = full_s;
  assign Data_out   = data_q;
  assign out_valid  = valid_q;
  assign credit_out = credit_q;
  assign credit_vc  = credit_vc_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_noc_vc_fifo.sv
// Bench for noc_vc_fifo (DEPTH=8, NUM_VC=2): table-driven vectors with a
// read-data scoreboard, plus hand-written full/empty/reset sequences.
module tb_noc_vc_fifo;
  import noc_pkg::*;

  localparam int DW = 8;
  localparam int DP = 8;
  localparam int NV = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          write, read;
  logic          wr_vc, rd_vc;
  logic [DW-1:0] data_out;
  logic          out_valid, credit_out, credit_vc, overflow, underflow;
  logic [NV-1:0] empty, full;
  logic [7:0]    count;

  always #5 clk = ~clk;

  noc_vc_fifo #(.DATA_W(DW), .DEPTH(DP), .NUM_VC(NV)) dut (
    .clk(clk), .rst(rst), .Data_in(data_in), .write(write), .wr_vc(wr_vc),
    .read(read), .rd_vc(rd_vc), .Data_out(data_out), .out_valid(out_valid),
    .empty(empty), .full(full), .count(count), .credit_out(credit_out),
    .credit_vc(credit_vc), .overflow(overflow), .underflow(underflow)
  );

  typedef struct {
    logic       w;
    logic       wv;
    logic [7:0] d;
    logic       r;
    logic       rv;
    logic [3:0] c0;
    logic [3:0] c1;
    logic       ov;
    logic       ud;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       vc;
  } sb_t;

  vec_t       tv[$];
  sb_t        sb[$];
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  int         checks = 0;
  int         errors = 0;

  function automatic vec_t mk(input logic w, input logic wv, input logic [7:0] d,
                              input logic r, input logic rv, input int c0,
                              input int c1, input logic ov, input logic ud);
    vec_t t;
    t.w = w; t.wv = wv; t.d = d; t.r = r; t.rv = rv;
    t.c0 = 4'(c0); t.c1 = 4'(c1); t.ov = ov; t.ud = ud;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " empty"}, 32'(empty), 32'h3);
    chk({tag, " full"}, 32'(full), 32'h0);
    chk({tag, " count"}, 32'(count), 32'h0);
    chk({tag, " Data_out"}, 32'(data_out), 32'h0);
    chk({tag, " out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, " credit_out"}, 32'(credit_out), 32'h0);
    chk({tag, " credit_vc"}, 32'(credit_vc), 32'h0);
    chk({tag, " overflow"}, 32'(overflow), 32'h0);
    chk({tag, " underflow"}, 32'(underflow), 32'h0);
  endtask

  // One clock of stimulus; expected read data is queued at drive time and
  // compared once the registered output appears.
  task automatic do_op(input logic w, input logic wv, input logic [7:0] d,
                       input logic r, input logic rv);
    int   rs, ws;
    logic racc, wacc;
    sb_t  e;
    rs   = rv ? mq1.size() : mq0.size();
    ws   = wv ? mq1.size() : mq0.size();
    racc = r && (rs > 0);
    wacc = w && ((ws < DP) || (racc && (rv == wv)));
    if (racc) begin
      e.vc = rv;
      if (rv) e.d = mq1.pop_front();
      else    e.d = mq0.pop_front();
      sb.push_back(e);
    end
    if (wacc) begin
      if (wv) mq1.push_back(d);
      else    mq0.push_back(d);
    end
    write = w; wr_vc = wv; data_in = d; read = r; rd_vc = rv;
    @(posedge clk);
    #1;
    write = 1'b0;
    read  = 1'b0;
    chk("out_valid", 32'(out_valid), 32'(racc));
    chk("credit_out", 32'(credit_out), 32'(racc));
    if (racc) begin
      e = sb.pop_front();
      chk("Data_out", 32'(data_out), 32'(e.d));
      chk("credit_vc", 32'(credit_vc), 32'(e.vc));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mq0.delete();
    mq1.delete();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; write = 1'b0; read = 1'b0;
    wr_vc = 1'b0; rd_vc = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("init");
    rst = 1'b1;

    // Fill VC0, overflow, drain, underflow, interleave, cross-VC independence.
    for (int i = 0; i < 8; i++) tv.push_back(mk(1'b1, 1'b0, 8'(i + 1), 1'b0, 1'b0, i + 1, 0, 1'b0, 1'b0));
    tv.push_back(mk(1'b1, 1'b0, 8'h09, 1'b0, 1'b0, 8, 0, 1'b1, 1'b0));
    for (int i = 0; i < 8; i++) tv.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 7 - i, 0, 1'b1, 1'b0));
    tv.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 1'b1, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 1, 0, 1'b1, 1'b1));
    tv.push_back(mk(1'b1, 1'b1, 8'hB1, 1'b0, 1'b0, 1, 1, 1'b1, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0, 2, 1, 1'b1, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2, 0, 1'b1, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 0, 1'b1, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 1'b1, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 1, 0, 1'b1, 1'b1));
    tv.push_back(mk(1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 0, 1, 1'b1, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1));

    foreach (tv[i]) begin
      do_op(tv[i].w, tv[i].wv, tv[i].d, tv[i].r, tv[i].rv);
      chk($sformatf("v%0d count0", i), 32'(count[3:0]), 32'(tv[i].c0));
      chk($sformatf("v%0d count1", i), 32'(count[7:4]), 32'(tv[i].c1));
      chk($sformatf("v%0d empty", i), 32'(empty), 32'({tv[i].c1 == 4'd0, tv[i].c0 == 4'd0}));
      chk($sformatf("v%0d full", i), 32'(full), 32'({tv[i].c1 == 4'd8, tv[i].c0 == 4'd8}));
      chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(tv[i].ov));
      chk($sformatf("v%0d underflow", i), 32'(underflow), 32'(tv[i].ud));
    end

    // Full VC with same-cycle read and write: both accepted, still full.
    do_reset();
    for (int i = 0; i < 8; i++) do_op(1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
    chk("full rw count0", 32'(count[3:0]), 32'd8);
    chk("full rw full0", 32'(full[0]), 32'd1);
    chk("full rw overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) do_op(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain empty0", 32'(empty[0]), 32'd1);

    // Empty VC with same-cycle read and write: no write-through.
    do_op(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    chk("empty rw underflow", 32'(underflow), 32'd1);
    chk("empty rw count1", 32'(count[7:4]), 32'd1);
    do_op(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a fill discards everything.
    for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0);
    chk("pre-rst count0", 32'(count[3:0]), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    check_reset("midrst");
    mq0.delete();
    mq1.delete();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst empty", 32'(empty), 32'h3);
    chk("post-rst count", 32'(count), 32'h0);
    do_op(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("post-rst underflow", 32'(underflow), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_vc_fifo.md
# noc_vc_fifo

Parametrised multi-virtual-channel flit buffer for the NoC router input port, generalising the single-queue 8-bit FIFO buffer. Holds NUM_VC independent FIFOs of DEPTH flits each in one shared storage array, tracks per-VC occupancy, and returns a credit to the upstream router for every flit read out. It sits between the link receiver and the router's VC allocator/crossbar.

## Interface
- DATA_W, 8: flit width in bits
- DEPTH, 8: entries per VC; power of two, ≥2
- NUM_VC, 2: number of virtual channels; ≥1
- VC_W, max(1, clog2(NUM_VC)): VC index width (derived)
- CNT_W, clog2(DEPTH)+1: occupancy width (derived)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Data_in  in  DATA_W  write flit
- write  in  1  write request
- wr_vc  in  VC_W  target VC of write
- read  in  1  read request
- rd_vc  in  VC_W  source VC of read
- Data_out  out  DATA_W  registered read flit
- out_valid  out  1  Data_out holds a flit from the previous cycle's accepted read
- empty  out  NUM_VC  per-VC empty flags
- full  out  NUM_VC  per-VC full flags
- count  out  NUM_VC*CNT_W  per-VC occupancy, VC i at bits [i*CNT_W +: CNT_W]
- credit_out  out  1  one-cycle credit pulse to upstream
- credit_vc  out  VC_W  VC the credit belongs to
- overflow  out  1  sticky: write to full VC dropped
- underflow  out  1  sticky: read from empty VC dropped

## Operation
- Storage: NUM_VC*DEPTH words; VC v entry p at address v*DEPTH + p.
- Per VC: wr_ptr, rd_ptr of clog2(DEPTH)+1 bits (extra wrap bit). empty = pointers equal; full = indices equal, wrap bits differ. count = wr_ptr − rd_ptr modulo 2^CNT_W.
- Write accepted when write=1 and (full[wr_vc]=0, or read=1 with rd_vc=wr_vc and read accepted). Accepted: store Data_in, wr_ptr[wr_vc]++.
- Read accepted when read=1 and empty[rd_vc]=0 as of the current cycle. A flit written this cycle is not readable until next cycle (no write-through on empty VC).
- Accepted read: Data_out <= mem[rd addr], rd_ptr[rd_vc]++, out_valid=1 next cycle, credit_out=1 and credit_vc=rd_vc next cycle.
- No accepted read: out_valid=0, credit_out=0 next cycle; Data_out holds last value.
- Rejected write sets overflow; rejected read sets underflow; both sticky until reset. Rejected ops change no pointer.
- wr_vc/rd_vc ≥ NUM_VC: request rejected, sets overflow/underflow respectively.
- Reads and writes on different VCs are fully independent every cycle.

## Timing
- Reset (rst=0, asynchronous assert, release synchronised by caller): all pointers 0; empty=all 1; full=all 0; count=0; Data_out=0; out_valid=0; credit_out=0; credit_vc=0; overflow=0; underflow=0. Memory contents not reset.
- Reset mid-operation discards all stored flits; no credit pulses issued for them.
- Read latency: 1 cycle (read at edge n → Data_out/out_valid/credit valid after edge n+1).
- Flags and count update on the edge of the accepted op; write→not-empty visible 1 cycle after write edge.
- Full VC, simultaneous read+write same VC: both accepted, count stays DEPTH, full stays 1.
- Empty VC, simultaneous read+write same VC: write accepted, read rejected, underflow=1, count=1.
- Pointer wrap: after DEPTH writes+reads, index returns to 0, wrap bit toggles; full/empty remain correct indefinitely.
- Max throughput: one write and one read per cycle.

## Structure
- Shared package noc_pkg: DATA_W, NUM_VC, VC_W defaults, flit-width constants used by the router.
- Sub-module vc_fifo_ctrl: per-VC pointer/flag/count logic (inputs wr_en, rd_en; outputs wr_idx, rd_idx, empty, full, count), instantiated NUM_VC times via generate. Storage array and accept/credit logic in noc_vc_fifo top.

## Test plan
- Reset then write 1..8 to VC0 (DEPTH=8) → full[0]=1, count VC0=8, empty[1]=1; 9th write (value 9) → dropped, overflow=1, count stays 8.
- Read VC0 8 times back-to-back → Data_out 1..8, one cycle after each read, 8 credit_out pulses with credit_vc=0; then empty[0]=1; further read → underflow=1, no credit.
- Interleave writes VC0=0xA1, VC1=0xB1, VC0=0xA2; read VC1 then VC0 twice → 0xB1, 0xA1, 0xA2 with matching credit_vc 1,0,0.
- VC0 full, same-cycle write 0x55 and read → read returns oldest flit, count stays 8, overflow=0; drain verifies 0x55 last.
- VC1 empty, same-cycle write 0x3C and read → underflow=1, count VC1=1; next-cycle read returns 0x3C.
- Fill VC0 with 5 flits, assert rst=0 mid-stream → all outputs at reset values immediately; after release empty=all 1, count=0.
